sub1_reg_reader: RTL

- Host-side read port for the sub1 register outputs: reg_a_0..4 (group A) and reg_b_0..2 (group B).
- Accepts read requests over a valid/ready channel and returns 8-bit data over a valid/ready response channel.
- Per-group snapshot gives coherent multi-register reads while sub1 keeps updating.
- Sits between sub1 and the host/debug interconnect; read-only, no side effects on sub1.

---
 rtl/sub1_reg_pkg.sv | 26 ++
 rtl/sub1_rsp_fifo.sv | 50 +++++
 rtl/sub1_reg_reader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sub1_reg_pkg.sv
// Shared address map, group sizes and types for the sub1 register read port.
package sub1_reg_pkg;

    localparam logic [3:0] ADDR_A0 = 4'h0;
    localparam logic [3:0] ADDR_A1 = 4'h1;
    localparam logic [3:0] ADDR_A2 = 4'h2;
    localparam logic [3:0] ADDR_A3 = 4'h3;
    localparam logic [3:0] ADDR_A4 = 4'h4;
    localparam logic [3:0] ADDR_B0 = 4'h8;
    localparam logic [3:0] ADDR_B1 = 4'h9;
    localparam logic [3:0] ADDR_B2 = 4'hA;

    localparam int N_REG_A = 5;
    localparam int N_REG_B = 3;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rsp_t;

    typedef enum logic {
        SNAP_IDLE = 1'b0,
        SNAP_HELD = 1'b1
    } snap_state_e;

endpackage

// File: rtl/sub1_rsp_fifo.sv
// Synchronous response FIFO; head entry reads as all-zero while empty.
module sub1_rsp_fifo
    import sub1_reg_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  rsp_t          push_data_i,
    input  logic          pop_i,
    output rsp_t          pop_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    rsp_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is not reset; stale entries are unreachable because the head is gated by empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/sub1_reg_reader.sv
// Host read port for sub1 registers: address decode, per-group snapshots,
// saturating error counter and an in-order response FIFO.
module sub1_reg_reader #(
    parameter bit P_SNAP_EN    = 1'b1,
    parameter int P_FIFO_DEPTH = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [3:0] i_req_addr,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic [7:0] o_rsp_data,
    output logic       o_rsp_err,
    output logic [7:0] o_err_cnt,
    output logic       o_snap_a_held,
    output logic       o_snap_b_held,
    input  logic [7:0] reg_a_0,
    input  logic [7:0] reg_a_1,
    input  logic [7:0] reg_a_2,
    input  logic [7:0] reg_a_3,
    input  logic [7:0] reg_a_4,
    input  logic [7:0] reg_b_0,
    input  logic [7:0] reg_b_1,
    input  logic [7:0] reg_b_2
);
    import sub1_reg_pkg::*;

    localparam int CNT_W = $clog2(P_FIFO_DEPTH) + 1;

    logic             req_fire, rsp_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    rsp_t             req_rsp, head_rsp;
    logic             in_a, in_b;
    logic [7:0]       live_a [N_REG_A];
    logic [7:0]       live_b [N_REG_B];
    logic [7:0]       snap_a_q [N_REG_A], snap_a_d [N_REG_A];
    logic [7:0]       snap_b_q [N_REG_B], snap_b_d [N_REG_B];
    snap_state_e      state_a_q, state_a_d, state_b_q, state_b_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    assign live_a = '{reg_a_0, reg_a_1, reg_a_2, reg_a_3, reg_a_4};
    assign live_b = '{reg_b_0, reg_b_1, reg_b_2};

    assign o_req_ready = !fifo_full;
    assign o_rsp_valid = !fifo_empty;
    assign req_fire    = i_req_valid && o_req_ready;
    assign rsp_pop     = o_rsp_valid && i_rsp_ready;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        in_a    = 1'b0;
        in_b    = 1'b0;
        req_rsp = '0;
        case (i_req_addr)
            ADDR_A0, ADDR_A1, ADDR_A2, ADDR_A3, ADDR_A4: in_a = 1'b1;
            ADDR_B0, ADDR_B1, ADDR_B2:                   in_b = 1'b1;
            default: ;
        endcase
        // The capture address always returns the live value, even when re-capturing.
        if (in_a) begin
            req_rsp.data = (state_a_q == SNAP_HELD && i_req_addr != ADDR_A0)
                         ? snap_a_q[i_req_addr[2:0]] : live_a[i_req_addr[2:0]];
        end else if (in_b) begin
            req_rsp.data = (state_b_q == SNAP_HELD && i_req_addr != ADDR_B0)
                         ? snap_b_q[i_req_addr[1:0]] : live_b[i_req_addr[1:0]];
        end else begin
            req_rsp.err = 1'b1;
        end
    end

    always_comb begin
        state_a_d = state_a_q;
        state_b_d = state_b_q;
        snap_a_d  = snap_a_q;
        snap_b_d  = snap_b_q;
        if (P_SNAP_EN && req_fire) begin
            if (i_req_addr == ADDR_A0) begin
                state_a_d = SNAP_HELD;
                snap_a_d  = live_a;
            end else if (i_req_addr == ADDR_A4) begin
                state_a_d = SNAP_IDLE;
            end
            if (i_req_addr == ADDR_B0) begin
                state_b_d = SNAP_HELD;
                snap_b_d  = live_b;
            end else if (i_req_addr == ADDR_B2) begin
                state_b_d = SNAP_IDLE;
            end
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (req_fire && req_rsp.err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_a_q <= SNAP_IDLE;
            state_b_q <= SNAP_IDLE;
            snap_a_q  <= '{default: '0};
            snap_b_q  <= '{default: '0};
            err_cnt_q <= '0;
        end else begin
            state_a_q <= state_a_d;
            state_b_q <= state_b_d;
            snap_a_q  <= snap_a_d;
            snap_b_q  <= snap_b_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    sub1_rsp_fifo #(.DEPTH(P_FIFO_DEPTH)) u_rsp_fifo (
        .clk_i       (i_clk),
        .rst_ni      (i_rst_n),
        .push_i      (req_fire),
        .push_data_i (req_rsp),
        .pop_i       (rsp_pop),
        .pop_data_o  (head_rsp),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign o_rsp_data    = head_rsp.data;
    assign o_rsp_err     = head_rsp.err;
    assign o_err_cnt     = err_cnt_q;
    assign o_snap_a_held = (state_a_q == SNAP_HELD);
    assign o_snap_b_held = (state_b_q == SNAP_HELD);

    a_full_matches_count: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        fifo_full == (fifo_count == CNT_W'(P_FIFO_DEPTH)));

endmodule
